i2c_slave_regfile: RTL and testbench

- I2C target (slave) for the I2C master: receives the address and register-address sequence, then writes data into an internal register file or returns data from it.
- Oversamples SCL/SDA on the system clock and drives SDA open-drain, active-low only.
- Sits on the shared I2C bus opposite the master; exposes a write-strobe side port for the host logic.

---
 rtl/i2c_slave_regfile.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a small register file.
// Address byte, register-pointer byte, then data bytes written with
// auto-increment; reads stream reg[pointer] onward until the master NACKs.
// Valid/ready note: the host side is a pure strobe interface; wr_strobe is a
// one-cycle valid with no back-pressure, wr_addr/wr_data are stable with it.
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1101001,
    parameter int         NUM_REGS   = 8,
    parameter int         AW         = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_REG,
        S_REG_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_MACK
    } state_t;

    state_t        r_state;

    // Synchronizer and one-deep history for both bus lines
    logic          r_scl_s1, r_scl_s2, r_scl_d;
    logic          r_sda_s1, r_sda_s2, r_sda_d;

    logic [7:0]    r_shift;      // receive shifter
    logic [7:0]    r_tx;         // transmit shifter, MSB is the bit on the bus
    logic [2:0]    r_bit_cnt;    // counts 7..0 through a byte
    logic          r_byte_done;  // 8th bit sampled, waiting for its SCL fall
    logic          r_rw;         // R/W bit of the matched address byte
    logic          r_commit;     // data byte complete, write it next cycle
    logic          r_mack_ok;    // master ACKed, next byte is loaded
    logic [AW-1:0] r_ptr;
    logic [7:0]    r_regs [NUM_REGS];

    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [AW-1:0] w_ptr_next;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_ptr_next = r_ptr + AW'(1);

    // Bring the asynchronous bus lines into the clk domain; idle bus is high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    // Protocol FSM, register file and host strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            sda_oe      <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_bit_cnt   <= 3'd7;
            r_byte_done <= 1'b0;
            r_rw        <= 1'b0;
            r_commit    <= 1'b0;
            r_mack_ok   <= 1'b0;
            r_ptr       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;

            // A completed data byte lands one clk after its 8th SCL rise
            if (r_commit) begin
                r_commit       <= 1'b0;
                r_regs[r_ptr]  <= r_shift;
                wr_strobe      <= 1'b1;
                wr_addr        <= r_ptr;
                wr_data        <= r_shift;
                r_ptr          <= w_ptr_next;
            end

            if (w_start) begin
                r_state     <= S_ADDR;
                r_bit_cnt   <= 3'd7;
                r_byte_done <= 1'b0;
                r_mack_ok   <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else if (w_stop) begin
                r_state     <= S_IDLE;
                r_mack_ok   <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (w_scl_rise && !r_byte_done) begin
                            r_shift <= {r_shift[6:0], r_sda_s2};
                            if (r_bit_cnt == 3'd0) begin
                                r_byte_done <= 1'b1;
                                if (r_state == S_WDATA) begin
                                    r_commit <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_bit_cnt   <= 3'd7;
                            if (r_state == S_ADDR) begin
                                if (r_shift[7:1] == SLAVE_ADDR) begin
                                    sda_oe  <= 1'b1;
                                    busy    <= 1'b1;
                                    r_rw    <= r_shift[0];
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else if (r_state == S_REG) begin
                                r_ptr   <= r_shift[AW-1:0];
                                sda_oe  <= 1'b1;
                                r_state <= S_REG_ACK;
                            end else begin
                                sda_oe  <= 1'b1;
                                r_state <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_tx      <= r_regs[r_ptr];
                                sda_oe    <= ~r_regs[r_ptr][7];
                                r_bit_cnt <= 3'd7;
                                r_state   <= S_RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= S_REG;
                            end
                        end
                    end
                    S_REG_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe  <= 1'b0;
                            r_state <= S_WDATA;
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                sda_oe    <= 1'b0;
                                r_mack_ok <= 1'b0;
                                r_state   <= S_MACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                                r_tx      <= {r_tx[6:0], 1'b0};
                                sda_oe    <= ~r_tx[6];
                            end
                        end
                    end
                    S_MACK: begin
                        if (w_scl_rise) begin
                            if (!r_sda_s2) begin
                                r_ptr     <= w_ptr_next;
                                r_tx      <= r_regs[w_ptr_next];
                                r_mack_ok <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else if (w_scl_fall && r_mack_ok) begin
                            r_mack_ok <= 1'b0;
                            r_bit_cnt <= 3'd7;
                            sda_oe    <= ~r_tx[7];
                            r_state   <= S_RDATA;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master, register-file model,
// write-strobe scoreboard.
module tb_i2c_slave_regfile;

    localparam int NREG = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_strobe;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  mdl_regs [NREG];
    int          mdl_ptr;
    logic [10:0] exp_q [$];
    logic [10:0] obs_q [$];
    logic [7:0]  wbuf [16];
    logic [7:0]  rbuf [16];
    logic [7:0]  erbuf [16];
    logic        oe_seen;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (m_scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write-strobe collector and SDA-drive monitor
    always @(negedge clk) begin
        if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_seen = 1'b1;
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) mdl_regs[i] = 8'h00;
        mdl_ptr = 0;
        exp_q.delete();
    endfunction

    function automatic void model_write(input logic [7:0] regb, input int n);
        logic [2:0] p;
        mdl_ptr = int'(regb) % NREG;
        for (int k = 0; k < n; k++) begin
            p = 3'(mdl_ptr);
            mdl_regs[mdl_ptr] = wbuf[k];
            exp_q.push_back({p, wbuf[k]});
            mdl_ptr = (mdl_ptr + 1) % NREG;
        end
    endfunction

    function automatic void model_read(input int n);
        for (int k = 0; k < n; k++) begin
            erbuf[k] = mdl_regs[mdl_ptr];
            if (k < n - 1) mdl_ptr = (mdl_ptr + 1) % NREG;
        end
    endfunction

    // ---------------- master driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(4);
        m_sda = b;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(10);
        m_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_clk(4);
        m_sda = 1'b1;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(5);
        b = sda_bus;
        wait_clk(5);
        m_scl = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(4);
        m_sda = 1'b1;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b0;
        wait_clk(10);
        m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4);
        m_sda = 1'b0;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(10);
        m_sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_byte(input logic [7:0] b, output int acked);
        logic bit_v;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(bit_v);
        acked = bit_v ? 0 : 1;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bit_v);
            d[i] = bit_v;
        end
        send_bit(ack ? 1'b0 : 1'b1);
    endtask

    task automatic xfer_write(input logic [7:0] regb, input int n, output int acks);
        int a;
        acks = 0;
        bus_start();
        send_byte(8'hD2, a); acks += a;
        send_byte(regb, a);  acks += a;
        for (int k = 0; k < n; k++) begin
            send_byte(wbuf[k], a);
            acks += a;
        end
    endtask

    task automatic xfer_set_ptr(input logic [7:0] regb, output int acks);
        int a;
        acks = 0;
        bus_start();
        send_byte(8'hD2, a); acks += a;
        send_byte(regb, a);  acks += a;
    endtask

    task automatic xfer_read(input int n, output int acks);
        logic [7:0] d;
        bus_start();
        send_byte(8'hD3, acks);
        for (int k = 0; k < n; k++) begin
            recv_byte(k < n - 1, d);
            rbuf[k] = d;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        wait_clk(3);
        n_total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); else n_pass++;
        n_total++; if (wr_addr !== 3'd0) $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        model_reset();
        obs_q.delete();
        wait_clk(5);
    endtask

    task automatic test_write();
        int acks;
        wbuf[0] = 8'hA5;
        xfer_write(8'h03, 1, acks);
        model_write(8'h03, 1);
        n_total++; if (acks !== 3) $display("FAIL write_acks: got %0d want 3", acks); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL write_busy_before_stop: got %b want 1", busy); else n_pass++;
        bus_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL write_busy_after_stop: got %b want 0", busy); else n_pass++;
        n_total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL write_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL write_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_read();
        int a1, a2;
        xfer_set_ptr(8'h03, a1);
        mdl_ptr = 3;
        xfer_read(1, a2);
        model_read(1);
        n_total++; if (a1 + a2 !== 3) $display("FAIL read_acks: got %0d want 3", a1 + a2); else n_pass++;
        n_total++; if (rbuf[0] !== erbuf[0]) $display("FAIL read_data: got %h want %h", rbuf[0], erbuf[0]); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL read_busy_after_nack: got %b want 1", busy); else n_pass++;
        bus_stop();
        n_total++; if (busy !== 1'b0) $display("FAIL read_busy_after_stop: got %b want 0", busy); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL read_no_strobe: got %0d strobes want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_mismatch();
        int a1, a2;
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'hA0, a1);
        send_byte(8'h11, a2);
        n_total++; if (busy !== 1'b0) $display("FAIL mismatch_busy: got %b want 0", busy); else n_pass++;
        bus_stop();
        n_total++; if (oe_seen !== 1'b0) $display("FAIL mismatch_sda_oe: got %b want 0", oe_seen); else n_pass++;
        n_total++; if (a1 + a2 !== 0) $display("FAIL mismatch_acks: got %0d want 0", a1 + a2); else n_pass++;
        n_total++; if (obs_q.size() != 0) $display("FAIL mismatch_no_strobe: got %0d want 0", obs_q.size()); else n_pass++;
        // full register dump must match the model
        xfer_set_ptr(8'h00, a1);
        mdl_ptr = 0;
        xfer_read(NREG, a2);
        model_read(NREG);
        bus_stop();
        for (int k = 0; k < NREG; k++) begin
            n_total++;
            if (rbuf[k] !== erbuf[k]) $display("FAIL mismatch_regs[%0d]: got %h want %h", k, rbuf[k], erbuf[k]);
            else n_pass++;
        end
        obs_q.delete();
    endtask

    task automatic test_burst_wrap();
        int acks, a2;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        xfer_write(8'h06, 3, acks);
        model_write(8'h06, 3);
        bus_stop();
        n_total++; if (acks !== 5) $display("FAIL burst_acks: got %0d want 5", acks); else n_pass++;
        n_total++;
        if (obs_q.size() != exp_q.size()) $display("FAIL burst_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL burst_strobe[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        xfer_set_ptr(8'h06, acks);
        mdl_ptr = 6;
        xfer_read(3, a2);
        model_read(3);
        bus_stop();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (rbuf[k] !== erbuf[k]) $display("FAIL burst_read[%0d]: got %h want %h", k, rbuf[k], erbuf[k]);
            else n_pass++;
        end
        n_total++; if (obs_q.size() != 0) $display("FAIL burst_read_no_strobe: got %0d want 0", obs_q.size()); else n_pass++;
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int acks, a2;
        bus_start();
        send_byte(8'hD2, acks);
        send_byte(8'h02, acks);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
        wait_clk(2);
        n_total++; if (sda_oe !== 1'b0) $display("FAIL midreset_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL midreset_wr_strobe: got %b want 0", wr_strobe); else n_pass++;
        n_total++; if (wr_addr !== 3'd0) $display("FAIL midreset_wr_addr: got %0d want 0", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 8'h00) $display("FAIL midreset_wr_data: got %h want 00", wr_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        model_reset();
        obs_q.delete();
        wait_clk(5);
        wbuf[0] = 8'h5A;
        xfer_write(8'h01, 1, acks);
        model_write(8'h01, 1);
        bus_stop();
        n_total++; if (acks !== 3) $display("FAIL midreset_write_acks: got %0d want 3", acks); else n_pass++;
        n_total++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) $display("FAIL midreset_write_strobe: got %0d strobes first %h want 1 of %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 11'h0, exp_q[0]);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
        xfer_set_ptr(8'h00, acks);
        mdl_ptr = 0;
        xfer_read(NREG, a2);
        model_read(NREG);
        bus_stop();
        for (int k = 0; k < NREG; k++) begin
            n_total++;
            if (rbuf[k] !== erbuf[k]) $display("FAIL midreset_regs[%0d]: got %h want %h", k, rbuf[k], erbuf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        int acks, a2;
        wbuf[0] = 8'($urandom_range(0, 255));
        xfer_write(8'h0B, 1, acks);
        model_write(8'h0B, 1);
        bus_stop();
        n_total++; if (acks !== 3) $display("FAIL oor_acks: got %0d want 3", acks); else n_pass++;
        n_total++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) $display("FAIL oor_strobe: got %0d strobes first %h want 1 of %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 11'h0, exp_q[0]);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
        xfer_set_ptr(8'h03, acks);
        mdl_ptr = 3;
        xfer_read(1, a2);
        model_read(1);
        bus_stop();
        n_total++; if (rbuf[0] !== erbuf[0]) $display("FAIL oor_readback: got %h want %h", rbuf[0], erbuf[0]); else n_pass++;
    endtask

    task automatic test_random();
        int acks, a2, n, nr;
        logic [7:0] regb;
        for (int it = 0; it < 5; it++) begin
            regb = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom_range(0, 255));
            xfer_write(regb, n, acks);
            model_write(regb, n);
            bus_stop();
            n_total++; if (acks !== n + 2) $display("FAIL rand%0d_acks: got %0d want %0d", it, acks, n + 2); else n_pass++;
            n_total++;
            if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_strobe_count: got %0d want %0d", it, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_strobe[%0d]: got %h want %h", it, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
            obs_q.delete(); exp_q.delete();
            // read either from a fresh pointer or from wherever it was left
            nr = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                regb = 8'($urandom_range(0, 255));
                xfer_set_ptr(regb, acks);
                mdl_ptr = int'(regb) % NREG;
            end
            xfer_read(nr, a2);
            model_read(nr);
            bus_stop();
            for (int k = 0; k < nr; k++) begin
                n_total++;
                if (rbuf[k] !== erbuf[k]) $display("FAIL rand%0d_read[%0d]: got %h want %h", it, k, rbuf[k], erbuf[k]);
                else n_pass++;
            end
            n_total++; if (obs_q.size() != 0) $display("FAIL rand%0d_read_no_strobe: got %0d want 0", it, obs_q.size()); else n_pass++;
            obs_q.delete();
        end
    endtask

    initial begin
        oe_seen = 1'b0;
        model_reset();
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_burst_wrap();
        test_reset_mid();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
